// File: rtl/regfile_2r1w.sv
// Two-read / one-write register file with registered read data and a power-up clear sweep.
// Optional macro REGFILE_ZERO_REG_EN makes entry 0 a hard-wired zero register.
module regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] rd_a_nxt;
    logic [DATA_W-1:0] rd_b_nxt;

    assign ready = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                if (clr) begin
                    clr_cnt_nxt = '0;
                end else if (&clr_cnt) begin
                    state_nxt   = RUN;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            RUN: begin
                if (clr) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // A soft clear in the same cycle drops any access.
    always_comb begin
        wr_ok = ready && !cs_n && we && !clr;
        rd_ok = ready && !cs_n && re && !clr;
`ifdef REGFILE_ZERO_REG_EN
        if (waddr == '0) begin
            wr_ok = 1'b0;
        end
`endif
    end

    always_comb begin
        rd_a_nxt = '0;
        rd_b_nxt = '0;
        if (rd_ok) begin
            rd_a_nxt = (wr_ok && (waddr == raddr_a)) ? wdata : mem[raddr_a];
            rd_b_nxt = (wr_ok && (waddr == raddr_b)) ? wdata : mem[raddr_b];
`ifdef REGFILE_ZERO_REG_EN
            if (raddr_a == '0) begin
                rd_a_nxt = '0;
            end
            if (raddr_b == '0) begin
                rd_b_nxt = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
            rvalid  <= 1'b0;
        end else begin
            rdata_a <= rd_a_nxt;
            rdata_b <= rd_b_nxt;
            rvalid  <= rd_ok;
        end
    end

    // The array has no reset; the CLEAR sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomized and directed bench for regfile_2r1w against an array-based reference model.
// Follows REGFILE_ZERO_REG_EN so the same bench covers both builds.
module tb_regfile_2r1w;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk;
    logic          rst_n;
    logic          cs_n;
    logic          clr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re;
    logic [AW-1:0] raddr_a;
    logic [AW-1:0] raddr_b;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic          rvalid;
    logic          ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents, readiness, and edges left until the sweep completes.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_ready;
    int            m_sweep;

    regfile_2r1w #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .clr(clr), .we(we),
        .waddr(waddr), .wdata(wdata), .re(re),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .rvalid(rvalid), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input bit wr,
                                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 0) return '0;
`endif
        if (wr && wa == a) return wd;
        return m_mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_ready = 0;
        m_sweep = DEPTH;
    endtask

    // One clock cycle: drive, predict, clock, check, then advance the model.
    task automatic applyStimulus(input logic c_n, input logic cl, input logic w,
                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic r, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        bit            acc;
        bit            wr;
        bit            rd;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        cs_n = c_n; clr = cl; we = w; waddr = wa; wdata = wd;
        re = r; raddr_a = ra; raddr_b = rb;
        acc = m_ready && !c_n && !cl;
        wr  = acc && w;
`ifdef REGFILE_ZERO_REG_EN
        if (wa == 0) wr = 0;
`endif
        rd    = acc && r;
        exp_a = rd ? model_read(ra, wr, wa, wd) : '0;
        exp_b = rd ? model_read(rb, wr, wa, wd) : '0;
        @(posedge clk);
        #1;
        if (m_ready) begin
            if (cl) model_clear();
            else if (wr) m_mem[wa] = wd;
        end else begin
            m_sweep = cl ? DEPTH : m_sweep - 1;
            if (m_sweep == 0) m_ready = 1;
        end
        checkOutput("rdata_a", rdata_a, exp_a);
        checkOutput("rdata_b", rdata_b, exp_b);
        checkOutput("rvalid", {31'd0, rvalid}, {31'd0, rd});
        checkOutput("ready", {31'd0, ready}, {31'd0, m_ready});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        applyStimulus(0, 0, 1, a, d, 0, 0, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        applyStimulus(0, 0, 0, 0, 0, 1, a, b);
    endtask

    // Asserts reset between edges and checks that outputs drop without a clock.
    task automatic do_reset();
        cs_n = 1; clr = 0; we = 0; re = 0;
        rst_n = 1'b0;
        #2;
        checkOutput("rst_rdata_a", rdata_a, '0);
        checkOutput("rst_rdata_b", rdata_b, '0);
        checkOutput("rst_rvalid", {31'd0, rvalid}, '0);
        checkOutput("rst_ready", {31'd0, ready}, '0);
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 0; cs_n = 1; clr = 0; we = 0; waddr = 0; wdata = 0;
        re = 0; raddr_a = 0; raddr_b = 0;
        model_clear();

        // Power-up sweep, then every entry reads back zero.
        do_reset();
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i), AW'(DEPTH - 1 - i));

        do_write(7, 32'hDEADBEEF);
        do_read(7, 7);

        do_write(4, 32'h000000A5);
        applyStimulus(0, 0, 1, 3, 32'h12345678, 1, 3, 4);

        do_write(5, 32'h0BAD0BAD);
        applyStimulus(1, 0, 1, 5, 32'h11111111, 1, 5, 5);
        do_read(5, 5);

        // Address 0: zero register or ordinary register depending on the build.
        applyStimulus(0, 0, 1, 0, 32'h00000055, 1, 0, 0);
        do_read(0, 0);

        // Clear wins over a simultaneous write/read.
        do_write(9, 32'h000000FF);
        applyStimulus(0, 1, 1, 9, 32'h77777777, 1, 9, 7);
        idle(DEPTH);
        do_read(9, 7);

        // Clear re-requested mid-sweep restarts it.
        do_write(9, 32'h000000FF);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        idle(10);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        idle(DEPTH);
        do_read(9, 9);

        // Reset mid-sweep restarts it from entry 0.
        do_write(9, 32'h000000FF);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        idle(10);
        do_reset();
        idle(DEPTH);
        do_read(9, 9);

        for (int i = 0; i < 600; i++) begin
            logic          c_n;
            logic          cl;
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            logic [AW-1:0] rb;
            c_n = ($urandom_range(0, 7) == 0);
            cl  = ($urandom_range(0, 149) == 0);
            wa  = AW'($urandom_range(0, DEPTH - 1));
            ra  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            rb  = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, DEPTH - 1));
            applyStimulus(c_n, cl, 1'($urandom_range(0, 1)), wa, $urandom(),
                          1'($urandom_range(0, 1)), ra, rb);
        end

        // Reset in the middle of a valid read with nonzero data.
        while (!m_ready) idle(1);
        do_write(12, 32'hCAFEF00D);
        do_read(12, 12);
        do_reset();
        idle(DEPTH);
        do_read(12, 7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cs_n  input  1  chip select, active low; when high, reads and writes are ignored.
REQ-006 SHALL have port clr  input  1  synchronous soft-clear request.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port waddr  input  ADDR_W  write address.
REQ-009 SHALL have port wdata  input  DATA_W  write data.
REQ-010 SHALL have port re  input  1  read enable for both ports.
REQ-011 SHALL have ports raddr_a and raddr_b  input  ADDR_W each  read addresses.
REQ-012 SHALL have ports rdata_a and rdata_b  output  DATA_W each  registered read data.
REQ-013 SHALL have port rvalid  output  1  rdata_a/rdata_b hold a valid read this cycle.
REQ-014 SHALL have port ready  output  1  array initialised; accesses accepted.

Function
REQ-015 SHALL implement FSM states CLEAR and RUN; ready = 1 exactly when state is RUN.
REQ-016 In CLEAR, each cycle SHALL write 0 to entry clr_cnt and increment clr_cnt; after writing entry DEPTH-1, it SHALL move to RUN, so ready rises on the DEPTH-th rising edge after rst_n deasserts.
REQ-017 clr=1 in RUN SHALL move the block to CLEAR with clr_cnt=0, so ready is low on the next cycle; clr=1 in CLEAR SHALL restart clr_cnt at 0.
REQ-018 In CLEAR, we and re SHALL be ignored: no array write, rvalid=0.
REQ-019 Write: ready && !cs_n && we && !clr SHALL update mem[waddr] with wdata at the rising edge.
REQ-020 Read: ready && !cs_n && re && !clr SHALL, at the rising edge, load rdata_a from mem[raddr_a] and rdata_b from mem[raddr_b] and set rvalid=1; latency is one cycle.
REQ-021 Any cycle not satisfying REQ-020 SHALL load rdata_a=0, rdata_b=0 and rvalid=0 at the rising edge.
REQ-022 Simultaneous read and write SHALL be allowed; when raddr_x equals waddr for an accepted write, rdata_x SHALL return wdata (write-first bypass).
REQ-023 Both read ports MAY address the same entry; both SHALL return identical data.
REQ-024 clr and an access in the same RUN cycle: clr SHALL win; the access is dropped.

Reset
REQ-025 rst_n low SHALL force state=CLEAR, clr_cnt=0, ready=0, rvalid=0, rdata_a=0 and rdata_b=0 immediately, regardless of clk.
REQ-026 Array contents SHALL NOT be reset asynchronously; they are zeroed by the CLEAR sweep.
REQ-027 Asserting rst_n mid-sweep or mid-access SHALL abort it; the sweep restarts from entry 0 after release.

Configuration
REQ-028 With macro REGFILE_ZERO_REG_EN defined, entry 0 SHALL always read as 0, writes to address 0 SHALL be discarded, and no bypass SHALL apply for address 0.
REQ-029 Without REGFILE_ZERO_REG_EN, entry 0 SHALL behave as an ordinary register.

Verification
REQ-030 Reset release, DEPTH=32: ready=0 for 31 edges and 1 after the 32nd edge; reads of all 32 entries return 0.
REQ-031 Write 0xDEADBEEF to address 7, then read with raddr_a=7 and raddr_b=7: next cycle both ports return 0xDEADBEEF and rvalid=1.
REQ-032 In one cycle, write 0x12345678 to address 3 and read with raddr_a=3 and raddr_b=4 (address 4 holds 0xA5): result is rdata_a=0x12345678 and rdata_b=0xA5.
REQ-033 cs_n=1 with we=1 to address 5, then read address 5 with cs_n=0: the old value is returned; the cycle with cs_n=1 gives rvalid=0 and rdata=0.
REQ-034 Pulse clr in RUN after writing 0xFF to address 9: ready is low for 32 cycles, and the subsequent read of address 9 returns 0; a repeat with rst_n pulsed mid-sweep also restarts the sweep.
REQ-035 With REGFILE_ZERO_REG_EN, write 0x55 to address 0 and read the same cycle and the next cycle: both reads return 0; without the macro, the results are 0x55 via bypass, then 0x55.
